// File: rtl/antenna_select_encoder.sv
// Antenna-select front end: per-radio button debounce, one-hot to BCD encode,
// collision refusal and break-before-make sequencing of the relay codes.

module asel_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] btn,
  output logic       evt,
  output logic [2:0] code
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [5:0]       sync_p0, sync_p1, samp_p2, deb_p3, deb_p4;
  logic [CNT_W-1:0] stable_cnt;

  function automatic logic [2:0] onehot_to_bcd(input logic [5:0] v);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < 6; i++)
      if (v[i]) c = 3'(i + 1);
    return c;
  endfunction

  // Stage p0/p1: metastability synchroniser
  always_ff @(posedge clk) begin
    sync_p0 <= btn;
    sync_p1 <= sync_p0;
  end

  // Stage p2/p3: stability counter saturates, debounced vector follows once stable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_p2    <= '0;
      stable_cnt <= '0;
      deb_p3     <= '0;
      deb_p4     <= '0;
    end else begin
      deb_p4 <= deb_p3;
      if (sync_p1 != samp_p2) begin
        samp_p2    <= sync_p1;
        stable_cnt <= '0;
      end else if (stable_cnt != CNT_MAX) begin
        stable_cnt <= stable_cnt + CNT_W'(1);
      end else begin
        deb_p3 <= samp_p2;
      end
    end
  end

  // Stage p4: edge detect; only a change into a one-hot pattern is a press
  assign evt  = (deb_p3 != deb_p4) && $onehot(deb_p3);
  assign code = onehot_to_bcd(deb_p3);
endmodule

module antenna_select_encoder #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int DEADTIME_CYCLES = 100000
) (
  input  logic       I_clk,
  input  logic       I_rst,
  input  logic [5:0] I_btn_A,
  input  logic [5:0] I_btn_B,
  output logic [2:0] O_A,
  output logic [2:0] O_B,
  output logic       O_busy_A,
  output logic       O_busy_B,
  output logic       O_reject
);
  localparam int DT_W = $clog2(DEADTIME_CYCLES + 1);
  localparam logic [DT_W-1:0] DT_LAST = DT_W'(DEADTIME_CYCLES - 1);

  typedef enum logic {ST_IDLE, ST_BREAK} state_t;

  state_t          st_a, st_b;
  logic [2:0]      cur_a, cur_b, tgt_a, tgt_b;
  logic [DT_W-1:0] dt_cnt_a, dt_cnt_b;
  logic            evt_a, evt_b;
  logic [2:0]      code_a, code_b, new_a, new_b;
  logic [2:0]      res_a, res_b, res_a_nxt;
  logic            try_a, try_b, rej_a, rej_b, acc_a, acc_b;

  function automatic logic [2:0] toggle_target(input logic [2:0] code, input logic [2:0] cur);
    return (code == cur) ? 3'd0 : code;
  endfunction

  asel_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk(I_clk), .rst(I_rst), .btn(I_btn_A), .evt(evt_a), .code(code_a)
  );
  asel_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk(I_clk), .rst(I_rst), .btn(I_btn_B), .evt(evt_b), .code(code_b)
  );

  // A has priority: B is checked against A's reservation as it will be next cycle
  always_comb begin
    new_a     = toggle_target(code_a, cur_a);
    new_b     = toggle_target(code_b, cur_b);
    res_a     = (st_a == ST_IDLE) ? cur_a : tgt_a;
    res_b     = (st_b == ST_IDLE) ? cur_b : tgt_b;
    try_a     = evt_a && (st_a == ST_IDLE);
    try_b     = evt_b && (st_b == ST_IDLE);
    rej_a     = try_a && (new_a != 3'd0) && (new_a == res_b);
    acc_a     = try_a && !rej_a;
    res_a_nxt = acc_a ? new_a : res_a;
    rej_b     = try_b && (new_b != 3'd0) && (new_b == res_a_nxt);
    acc_b     = try_b && !rej_b;
  end

  // Stage p5: break-before-make sequencers with registered outputs
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      st_a     <= ST_IDLE;
      cur_a    <= '0;
      tgt_a    <= '0;
      dt_cnt_a <= '0;
      O_A      <= '0;
      O_busy_A <= 1'b0;
    end else if (st_a == ST_IDLE) begin
      if (acc_a) begin
        st_a     <= ST_BREAK;
        tgt_a    <= new_a;
        dt_cnt_a <= '0;
        O_A      <= '0;
        O_busy_A <= 1'b1;
      end
    end else if (dt_cnt_a == DT_LAST) begin
      st_a     <= ST_IDLE;
      cur_a    <= tgt_a;
      O_A      <= tgt_a;
      O_busy_A <= 1'b0;
    end else begin
      dt_cnt_a <= dt_cnt_a + DT_W'(1);
    end
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      st_b     <= ST_IDLE;
      cur_b    <= '0;
      tgt_b    <= '0;
      dt_cnt_b <= '0;
      O_B      <= '0;
      O_busy_B <= 1'b0;
    end else if (st_b == ST_IDLE) begin
      if (acc_b) begin
        st_b     <= ST_BREAK;
        tgt_b    <= new_b;
        dt_cnt_b <= '0;
        O_B      <= '0;
        O_busy_B <= 1'b1;
      end
    end else if (dt_cnt_b == DT_LAST) begin
      st_b     <= ST_IDLE;
      cur_b    <= tgt_b;
      O_B      <= tgt_b;
      O_busy_B <= 1'b0;
    end else begin
      dt_cnt_b <= dt_cnt_b + DT_W'(1);
    end
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) O_reject <= 1'b0;
    else       O_reject <= rej_a || rej_b;
  end
endmodule

// File: tb/tb_antenna_select_encoder.sv
// Directed bench for antenna_select_encoder with short debounce and dead time.

module tb_antenna_select_encoder;
  localparam int DB = 4;
  localparam int DT = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] btn_a, btn_b;
  logic [2:0] o_a, o_b;
  logic       busy_a, busy_b, rej;

  int   errors = 0;
  int   checks = 0;
  int   rej_cnt = 0;
  int   rise_a = 0;
  int   inv_err = 0;
  logic busy_a_q = 1'b0;

  always #5 clk = ~clk;

  antenna_select_encoder #(.DEBOUNCE_CYCLES(DB), .DEADTIME_CYCLES(DT)) dut (
    .I_clk(clk), .I_rst(rst), .I_btn_A(btn_a), .I_btn_B(btn_b),
    .O_A(o_a), .O_B(o_b), .O_busy_A(busy_a), .O_busy_B(busy_b), .O_reject(rej)
  );

  // Event monitor: reject pulses, A sequence starts, and the no-shared-antenna invariant
  always @(negedge clk) begin
    if (rej) rej_cnt++;
    if (busy_a && !busy_a_q) rise_a++;
    busy_a_q = busy_a;
    if (o_a == o_b && o_a != 3'd0) inv_err++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy_a(output bit ok);
    int n = 0;
    while (!busy_a && n < 40) begin tick(); n++; end
    ok = busy_a;
  endtask

  task automatic wait_busy_b(output bit ok);
    int n = 0;
    while (!busy_b && n < 40) begin tick(); n++; end
    ok = busy_b;
  endtask

  task automatic test_reset();
    rst = 1'b1; btn_a = '0; btn_b = '0;
    repeat (3) tick();
    checks++; if (o_a !== 3'd0)   begin errors++; $display("FAIL reset_o_a got=%0d exp=0", o_a); end
    checks++; if (o_b !== 3'd0)   begin errors++; $display("FAIL reset_o_b got=%0d exp=0", o_b); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy_a got=%0b exp=0", busy_a); end
    checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL reset_busy_b got=%0b exp=0", busy_b); end
    checks++; if (rej !== 1'b0)    begin errors++; $display("FAIL reset_reject got=%0b exp=0", rej); end
    rst = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_select_a();
    int r0 = rej_cnt;
    bit ok;
    bit b_seen = 1'b0;
    btn_a = 6'b000100;
    wait_busy_a(ok);
    checks++; if (!ok) begin errors++; $display("FAIL select_a_start got=timeout exp=busy_a"); end
    for (int i = 0; i < DT; i++) begin
      checks++; if (o_a !== 3'd0)    begin errors++; $display("FAIL select_a_break_code cyc=%0d got=%0d exp=0", i, o_a); end
      checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL select_a_break_busy cyc=%0d got=%0b exp=1", i, busy_a); end
      if (o_b != 3'd0) b_seen = 1'b1;
      tick();
    end
    checks++; if (o_a !== 3'd3)    begin errors++; $display("FAIL select_a_make got=%0d exp=3", o_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL select_a_busy_end got=%0b exp=0", busy_a); end
    checks++; if (b_seen || o_b !== 3'd0) begin errors++; $display("FAIL select_a_o_b got=%0d exp=0", o_b); end
    checks++; if (rej_cnt != r0)   begin errors++; $display("FAIL select_a_reject got=%0d exp=0", rej_cnt - r0); end
    btn_a = '0;
    repeat (15) tick();
    checks++; if (o_a !== 3'd3)    begin errors++; $display("FAIL release_no_event got=%0d exp=3", o_a); end
  endtask

  task automatic test_collision();
    int r0 = rej_cnt;
    bit ok;
    btn_b = 6'b000100;
    repeat (20) tick();
    checks++; if (rej_cnt - r0 != 1) begin errors++; $display("FAIL collide_reject got=%0d exp=1", rej_cnt - r0); end
    checks++; if (o_b !== 3'd0)      begin errors++; $display("FAIL collide_o_b got=%0d exp=0", o_b); end
    checks++; if (busy_b !== 1'b0)   begin errors++; $display("FAIL collide_busy_b got=%0b exp=0", busy_b); end
    btn_b = '0;
    repeat (12) tick();
    btn_b = 6'b010000;
    wait_busy_b(ok);
    checks++; if (!ok)          begin errors++; $display("FAIL select_b_start got=timeout exp=busy_b"); end
    checks++; if (o_b !== 3'd0) begin errors++; $display("FAIL select_b_break got=%0d exp=0", o_b); end
    repeat (DT) tick();
    checks++; if (o_b !== 3'd5) begin errors++; $display("FAIL select_b_make got=%0d exp=5", o_b); end
    checks++; if (o_a !== 3'd3) begin errors++; $display("FAIL select_b_o_a got=%0d exp=3", o_a); end
    btn_b = '0;
    repeat (12) tick();
  endtask

  task automatic test_simultaneous();
    int r0;
    bit ok;
    rst = 1'b1; tick(); rst = 1'b0; tick();
    r0 = rej_cnt;
    btn_a = 6'b000010; btn_b = 6'b000010;
    wait_busy_a(ok);
    checks++; if (!ok)             begin errors++; $display("FAIL simul_a_start got=timeout exp=busy_a"); end
    checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL simul_busy_b got=%0b exp=0", busy_b); end
    repeat (DT) tick();
    checks++; if (o_a !== 3'd2)      begin errors++; $display("FAIL simul_o_a got=%0d exp=2", o_a); end
    checks++; if (o_b !== 3'd0)      begin errors++; $display("FAIL simul_o_b got=%0d exp=0", o_b); end
    checks++; if (rej_cnt - r0 != 1) begin errors++; $display("FAIL simul_reject got=%0d exp=1", rej_cnt - r0); end
    btn_a = '0; btn_b = '0;
    repeat (12) tick();
  endtask

  task automatic test_deselect();
    bit ok;
    btn_a = 6'b000010;
    wait_busy_a(ok);
    checks++; if (!ok)          begin errors++; $display("FAIL desel_start got=timeout exp=busy_a"); end
    repeat (DT - 1) tick();
    checks++; if (o_a !== 3'd0 || busy_a !== 1'b1) begin errors++; $display("FAIL desel_break got=%0d/%0b exp=0/1", o_a, busy_a); end
    tick();
    checks++; if (o_a !== 3'd0)    begin errors++; $display("FAIL desel_end got=%0d exp=0", o_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL desel_busy got=%0b exp=0", busy_a); end
    btn_a = '0;
    repeat (12) tick();
    btn_b = 6'b000010;
    wait_busy_b(ok);
    checks++; if (!ok)          begin errors++; $display("FAIL desel_b_start got=timeout exp=busy_b"); end
    repeat (DT) tick();
    checks++; if (o_b !== 3'd2) begin errors++; $display("FAIL desel_b_make got=%0d exp=2", o_b); end
    btn_b = '0;
    repeat (12) tick();
  endtask

  task automatic test_chatter();
    int f0 = rise_a;
    for (int i = 0; i < 10; i++) begin
      btn_a = (i % 2 == 0) ? 6'b100000 : 6'b000000;
      repeat (2) tick();
    end
    btn_a = 6'b100000;
    repeat (30) tick();
    checks++; if (rise_a - f0 != 1) begin errors++; $display("FAIL chatter_events got=%0d exp=1", rise_a - f0); end
    checks++; if (o_a !== 3'd6)     begin errors++; $display("FAIL chatter_o_a got=%0d exp=6", o_a); end
    btn_a = '0;
    repeat (12) tick();
    btn_a = 6'b000011;
    repeat (25) tick();
    checks++; if (o_a !== 3'd6)     begin errors++; $display("FAIL twobtn_o_a got=%0d exp=6", o_a); end
    checks++; if (rise_a - f0 != 1) begin errors++; $display("FAIL twobtn_events got=%0d exp=1", rise_a - f0); end
    btn_a = '0;
    repeat (12) tick();
  endtask

  task automatic test_mid_reset();
    bit ok;
    bit late = 1'b0;
    btn_a = 6'b000100;
    wait_busy_a(ok);
    checks++; if (!ok) begin errors++; $display("FAIL midrst_start got=timeout exp=busy_a"); end
    repeat (3) tick();
    btn_a = '0;
    rst = 1'b1;
    #1;
    checks++; if (o_a !== 3'd0 || o_b !== 3'd0) begin errors++; $display("FAIL midrst_codes got=%0d/%0d exp=0/0", o_a, o_b); end
    checks++; if (busy_a !== 1'b0 || busy_b !== 1'b0 || rej !== 1'b0) begin errors++; $display("FAIL midrst_flags got=%0b%0b%0b exp=000", busy_a, busy_b, rej); end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (o_a != 3'd0 || busy_a) late = 1'b1;
      tick();
    end
    checks++; if (late) begin errors++; $display("FAIL midrst_late got=%0d exp=0", o_a); end
  endtask

  task automatic test_break_reserve();
    int r0 = rej_cnt;
    bit ok;
    btn_b = 6'b001000;
    repeat (3) tick();
    btn_a = 6'b001000;
    wait_busy_b(ok);
    checks++; if (!ok) begin errors++; $display("FAIL reserve_b_start got=timeout exp=busy_b"); end
    repeat (20) tick();
    checks++; if (rej_cnt - r0 != 1) begin errors++; $display("FAIL reserve_reject got=%0d exp=1", rej_cnt - r0); end
    checks++; if (o_a !== 3'd0)      begin errors++; $display("FAIL reserve_o_a got=%0d exp=0", o_a); end
    checks++; if (busy_a !== 1'b0)   begin errors++; $display("FAIL reserve_busy_a got=%0b exp=0", busy_a); end
    checks++; if (o_b !== 3'd4)      begin errors++; $display("FAIL reserve_o_b got=%0d exp=4", o_b); end
    btn_a = '0; btn_b = '0;
    repeat (5) tick();
    checks++; if (inv_err != 0)      begin errors++; $display("FAIL shared_antenna got=%0d exp=0", inv_err); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_select_a();
    test_collision();
    test_simultaneous();
    test_deselect();
    test_chatter();
    test_mid_reset();
    test_break_reserve();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
